// File: rtl/micro_sequencer.sv
// Micro-program sequencer: walks the micro-control store from an entry address,
// issues each micro-instruction to the decoder and resolves branch/halt/memory stalls.
module micro_sequencer #(
  parameter int MINST_WIDTH = 44,
  parameter int UPC_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [UPC_WIDTH-1:0]   entry_addr,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [UPC_WIDTH-1:0]   upc,
  output logic                   cs_req,
  output logic [UPC_WIDTH-1:0]   cs_addr,
  input  logic                   cs_valid,
  input  logic [MINST_WIDTH-1:0] cs_data,
  output logic [MINST_WIDTH-1:0] m_instruction,
  output logic                   minst_valid,
  input  logic                   cond_flag,
  input  logic                   mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_MEM
  } state_t;

  localparam logic [2:0] T_JUMP = 3'b100;
  localparam logic [2:0] T_COND = 3'b011;
  localparam logic [2:0] T_HALT = 3'b111;

  state_t                 state_q, state_d;
  logic [UPC_WIDTH-1:0]   upc_q, upc_d;
  logic [MINST_WIDTH-1:0] minst_q, minst_d;

  logic [2:0]             minst_type;
  logic [UPC_WIDTH-1:0]   branch_tgt;
  logic                   mem_en;
  logic [UPC_WIDTH-1:0]   upc_inc;

  assign minst_type = minst_q[MINST_WIDTH-1 -: 3];
  assign branch_tgt = minst_q[10 +: UPC_WIDTH];
  assign mem_en     = minst_q[7];
  assign upc_inc    = upc_q + {{(UPC_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    minst_d = minst_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          upc_d   = entry_addr;
        end
      end
      FETCH: begin
        if (cs_valid) begin
          minst_d = cs_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        case (minst_type)
          T_JUMP:  upc_d = branch_tgt;
          T_COND:  upc_d = cond_flag ? branch_tgt : upc_inc;
          T_HALT:  upc_d = upc_q;
          default: upc_d = upc_inc;
        endcase
        // A halt never waits on memory, even when it carries mem_en.
        if (minst_type == T_HALT) begin
          state_d = IDLE;
        end else if (mem_en && !mem_ack) begin
          state_d = WAIT_MEM;
        end else begin
          state_d = FETCH;
        end
      end
      WAIT_MEM: begin
        if (mem_ack) begin
          state_d = FETCH;
        end
      end
    endcase
    // Abort overrides everything but leaves the uPC and held instruction intact.
    if (abort) begin
      state_d = IDLE;
      upc_d   = upc_q;
      minst_d = minst_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      upc_q   <= '0;
      minst_q <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      minst_q <= minst_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign cs_req        = (state_q == FETCH);
  assign cs_addr       = upc_q;
  assign upc           = upc_q;
  assign m_instruction = minst_q;
  assign minst_valid   = (state_q == ISSUE) && !abort;
  assign done          = minst_valid && (minst_type == T_HALT);

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: a routine-level model predicts every issue
// (address, instruction, cycle, done); a negedge monitor checks what the DUT presents.
module tb_micro_sequencer;
  localparam int MW = 44;
  localparam int UW = 10;
  localparam int NSEQ = 64;

  logic          clk = 1'b0;
  logic          rst, start, abort, cs_valid, cond_flag, mem_ack;
  logic [UW-1:0] entry_addr;
  logic [MW-1:0] cs_data;
  logic          busy, done, cs_req, minst_valid;
  logic [UW-1:0] upc, cs_addr;
  logic [MW-1:0] m_instruction;

  micro_sequencer #(.MINST_WIDTH(MW), .UPC_WIDTH(UW)) dut (
    .clk(clk), .rst(rst), .start(start), .entry_addr(entry_addr), .abort(abort),
    .busy(busy), .done(done), .upc(upc), .cs_req(cs_req), .cs_addr(cs_addr),
    .cs_valid(cs_valid), .cs_data(cs_data), .m_instruction(m_instruction),
    .minst_valid(minst_valid), .cond_flag(cond_flag), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [UW-1:0] addr;
    logic [MW-1:0] ins;
    int            cyc;
    bit            halt;
  } exp_t;

  exp_t          expq[$];
  exp_t          e_m;
  logic [MW-1:0] rom [1024];
  int            lat_seq  [NSEQ];
  int            memd_seq [NSEQ];
  bit            cond_seq [NSEQ];
  bit            used     [1024];
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  int            routine_id = 0;
  int            seen_id = 0;
  int            fi, fcnt, ii, mcount;
  logic [63:0]   rnd_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor + control-store/memory responder.
  always @(negedge clk) begin
    if (seen_id != routine_id) begin
      seen_id = routine_id;
      fi = 0; fcnt = 0; ii = 0; mcount = 0;
    end
    rnd_m = {$urandom, $urandom};
    if (!rst) begin
      if (done && !minst_valid) chk("done_without_issue", 1, 0);
      if (minst_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_issue", 1, 0);
        end else begin
          e_m = expq.pop_front();
          chk("issue_upc", upc, e_m.addr);
          chk("issue_instr", m_instruction, e_m.ins);
          chk("issue_cycle", cyc, e_m.cyc);
          chk("issue_done", done, e_m.halt);
        end
        cond_flag = (ii < NSEQ) ? cond_seq[ii] : 1'b0;
        if (m_instruction[7] && m_instruction[43:41] != 3'b111) begin
          mcount  = (ii < NSEQ) ? memd_seq[ii] : 0;
          mem_ack = (mcount == 0);
        end else begin
          mcount  = 0;
          mem_ack = rnd_m[50];
        end
        ii++;
      end else begin
        cond_flag = rnd_m[51];
        if (mcount > 0) begin
          mcount--;
          mem_ack = (mcount == 0);
        end else begin
          mem_ack = cs_req ? rnd_m[52] : 1'b0;
        end
      end
      if (cs_req) begin
        chk("cs_addr_eq_upc", cs_addr, upc);
        if (expq.size() > 0) chk("cs_addr", cs_addr, expq[0].addr);
        if (fcnt >= ((fi < NSEQ) ? lat_seq[fi] : 0)) begin
          cs_valid = 1'b1;
          cs_data  = rom[cs_addr];
          fi++;
          fcnt = 0;
        end else begin
          cs_valid = 1'b0;
          cs_data  = rnd_m[MW-1:0];
          fcnt++;
        end
      end else begin
        cs_valid = rnd_m[53];
        cs_data  = rnd_m[MW-1:0];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] mk(input logic [2:0] t, input logic [UW-1:0] tgt, input bit mem);
    logic [63:0] r;
    logic [MW-1:0] w;
    r = {$urandom, $urandom};
    w = r[MW-1:0];
    w[43:41] = t;
    w[19:10] = tgt;
    w[7] = mem;
    return w;
  endfunction

  task automatic clear_seq();
    for (int k = 0; k < NSEQ; k++) begin
      lat_seq[k] = 0; memd_seq[k] = 0; cond_seq[k] = 1'b0;
    end
  endtask

  function automatic logic [UW-1:0] pick_unused();
    logic [UW-1:0] x;
    do x = UW'($urandom_range(0, 1023)); while (used[x]);
    return x;
  endfunction

  // Builds a loop-free random routine of len instructions ending in a halt.
  task automatic gen_routine(input logic [UW-1:0] entry, input int len);
    logic [UW-1:0] pc, nxt, tgt;
    logic [2:0]    t;
    bit            mem;
    for (int a = 0; a < 1024; a++) used[a] = 1'b0;
    pc = entry;
    for (int k = 0; k < len; k++) begin
      lat_seq[k]  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      memd_seq[k] = $urandom_range(0, 5);
      cond_seq[k] = 1'($urandom_range(0, 1));
      mem         = 1'($urandom_range(0, 1));
      used[pc]    = 1'b1;
      tgt         = UW'($urandom_range(0, 1023));
      if (k == len - 1) begin
        rom[pc] = mk(3'b111, tgt, mem);
      end else begin
        do t = 3'($urandom_range(0, 7)); while (t == 3'b111);
        if (t == 3'b100 || (t == 3'b011 && cond_seq[k])) begin
          tgt = pick_unused();
          nxt = tgt;
        end else begin
          nxt = pc + 1'b1;
          if (used[nxt]) begin
            if (t == 3'b011) cond_seq[k] = 1'b1;
            else t = 3'b100;
            tgt = pick_unused();
            nxt = tgt;
          end
        end
        rom[pc] = mk(t, tgt, mem);
        pc = nxt;
      end
    end
  endtask

  // Reference walk of the routine at instruction level, then start and wait for done.
  task automatic run_routine(input logic [UW-1:0] entry, input string tag);
    logic [UW-1:0] pc, nxt;
    logic [MW-1:0] ins;
    int            c, waitc, halt_cyc;
    routine_id++;
    pc = entry;
    c = cyc + 2 + lat_seq[0];
    halt_cyc = c;
    for (int k = 0; k < NSEQ - 1; k++) begin
      ins = rom[pc];
      expq.push_back('{pc, ins, c, ins[43:41] == 3'b111});
      if (ins[43:41] == 3'b111) begin
        halt_cyc = c;
        break;
      end
      case (ins[43:41])
        3'b100:  nxt = ins[19:10];
        3'b011:  nxt = cond_seq[k] ? ins[19:10] : pc + 1'b1;
        default: nxt = pc + 1'b1;
      endcase
      c += 2 + lat_seq[k+1] + (ins[7] ? memd_seq[k] : 0);
      pc = nxt;
    end
    entry_addr = entry;
    start = 1'b1;
    step();
    start = 1'b0;
    waitc = 0;
    while ((expq.size() > 0 || busy) && waitc < 3000) begin
      step();
      waitc++;
    end
    chk({tag, "_completed"}, waitc < 3000, 1);
    if (waitc >= 3000) expq.delete();
    chk({tag, "_busy_fall_cycle"}, cyc, halt_cyc + 1);
    chk({tag, "_final_upc"}, upc, pc);
    chk({tag, "_idle_no_req"}, cs_req, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_upc"}, upc, 0);
    chk({tag, "_cs_req"}, cs_req, 0);
    chk({tag, "_cs_addr"}, cs_addr, 0);
    chk({tag, "_minst"}, m_instruction, 0);
    chk({tag, "_minst_valid"}, minst_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; entry_addr = '0;
    cs_valid = 1'b0; cs_data = '0; cond_flag = 1'b0; mem_ack = 1'b0;
    for (int a = 0; a < 1024; a++) rom[a] = mk(3'($urandom_range(0, 7)), UW'($urandom_range(0, 1023)), 1'b0);
    clear_seq();
    repeat (3) step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Straight-line routine.
    clear_seq();
    rom[5] = mk(3'b000, 10'd99, 1'b0);
    rom[6] = mk(3'b000, 10'd98, 1'b0);
    rom[7] = mk(3'b111, 10'd97, 1'b0);
    run_routine(10'd5, "straight");

    // Unconditional branch.
    rom[10]  = mk(3'b100, 10'd200, 1'b0);
    rom[200] = mk(3'b111, 10'd0, 1'b0);
    run_routine(10'd10, "jump");

    // Conditional branch taken and not taken.
    rom[20] = mk(3'b011, 10'd40, 1'b0);
    rom[40] = mk(3'b111, 10'd1, 1'b0);
    rom[21] = mk(3'b111, 10'd2, 1'b0);
    cond_seq[0] = 1'b1;
    run_routine(10'd20, "cond_taken");
    cond_seq[0] = 1'b0;
    run_routine(10'd20, "cond_not_taken");

    // Memory stall of 4 cycles, then zero stall, with a mem_en halt that must not wait.
    clear_seq();
    rom[3] = mk(3'b000, 10'd500, 1'b1);
    rom[4] = mk(3'b111, 10'd0, 1'b1);
    memd_seq[0] = 4;
    run_routine(10'd3, "mem_stall4");
    memd_seq[0] = 0;
    run_routine(10'd3, "mem_stall0");

    // Control-store latency and uPC wrap.
    clear_seq();
    lat_seq[0] = 3; lat_seq[1] = 2;
    rom[1023] = mk(3'b000, 10'd5, 1'b0);
    rom[0]    = mk(3'b111, 10'd6, 1'b0);
    run_routine(10'd1023, "wrap_latency");

    // Abort during WAIT_MEM, start while busy, start+abort in IDLE.
    clear_seq();
    rom[50] = mk(3'b000, 10'd77, 1'b1);
    rom[51] = mk(3'b111, 10'd0, 1'b0);
    memd_seq[0] = 30;
    routine_id++;
    expq.push_back('{10'd50, rom[50], cyc + 2, 1'b0});
    entry_addr = 10'd50; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("abort_pre_busy", busy, 1);
    chk("abort_pre_upc", upc, 51);
    chk("abort_pre_issued", expq.size(), 0);
    entry_addr = 10'd300; start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy_ignored_upc", upc, 51);
    chk("start_busy_ignored_req", cs_req, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_upc_kept", upc, 51);
    chk("abort_minst_kept", m_instruction, rom[50]);
    routine_id++;
    step();
    step();
    chk("abort_stays_idle", busy, 0);
    entry_addr = 10'd9; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    chk("start_abort_upc", upc, 51);

    // Asynchronous reset in the middle of a FETCH handshake.
    clear_seq();
    lat_seq[0] = 20;
    rom[60] = mk(3'b111, 10'd0, 1'b0);
    routine_id++;
    expq.push_back('{10'd60, rom[60], cyc + 22, 1'b1});
    entry_addr = 10'd60; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("rst_pre_fetch", cs_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid_fetch");
    expq.delete();
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_release_idle", busy, 0);

    // Randomized routines.
    for (int r = 0; r < 25; r++) begin
      logic [UW-1:0] ent;
      ent = UW'($urandom_range(0, 1023));
      clear_seq();
      gen_routine(ent, $urandom_range(1, 10));
      run_routine(ent, "random");
      repeat ($urandom_range(0, 3)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
